// File: rtl/plot_fifo_pkg.sv
// Shared pixel/done definitions for the drawer pipeline (circle, line, plot_fifo).
package plot_fifo_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    typedef enum logic [1:0] {
        DONE_IDLE,
        DONE_PENDING,
        DONE_FIRE
    } done_state_t;

endpackage

// File: rtl/plot_fifo_sync_fifo.sv
// Single-clock FIFO with occupancy count; writes while full and reads while empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (do_pop && !do_push) count <= count - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/plot_fifo.sv
// Clips drawer pixels to the screen, buffers them, drains to the VGA adapter
// under valid/ready and pulses done once everything accepted has been delivered.
module plot_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned SCREEN_W = plot_fifo_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = plot_fifo_pkg::SCREEN_H
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_x,
    input  logic [6:0]  in_y,
    input  logic [2:0]  in_colour,
    input  logic        in_plot,
    input  logic        in_done,
    input  logic        stat_clr,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    input  logic        vga_ready,
    output logic        done,
    output logic        empty,
    output logic        overflow,
    output logic [15:0] clip_cnt
);

    import plot_fifo_pkg::*;

    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    pixel_t                 in_pix;
    pixel_t                 head;
    logic                   clipped;
    logic                   wr_en;
    logic                   ovf_event;
    logic                   load;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    done_state_t            state;
    done_state_t            state_n;
    logic                   wait_fall;

    assign in_pix    = {in_x, in_y, in_colour};
    assign clipped   = in_plot & (({1'b0, in_x} >= X_LIM) | ({1'b0, in_y} >= Y_LIM));
    // Full is judged on the start-of-cycle count, so a same-cycle read never makes room.
    assign wr_en     = in_plot & ~clipped & ~fifo_full;
    assign ovf_event = in_plot & ~clipped & fifo_full;
    assign load      = ~fifo_empty & (~vga_plot | vga_ready);
    assign empty     = (fifo_count == '0) & ~vga_plot;

    sync_fifo #(
        .WIDTH ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_en),
        .din   (in_pix),
        .pop   (load),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
        end else if (load) begin
            vga_x      <= head.x;
            vga_y      <= head.y;
            vga_colour <= head.colour;
            vga_plot   <= 1'b1;
        end else if (vga_ready) begin
            vga_plot   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            clip_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            if (clipped && clip_cnt != '1) clip_cnt <= clip_cnt + 16'd1;
            if (ovf_event)                 overflow <= 1'b1;
        end
    end

    // wait_fall blocks re-arming until in_done has dropped after a pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DONE_IDLE;
            wait_fall <= 1'b0;
        end else begin
            state <= state_n;
            if (state == DONE_FIRE && in_done) wait_fall <= 1'b1;
            else if (!in_done)                 wait_fall <= 1'b0;
        end
    end

    always_comb begin
        state_n = state;
        done    = 1'b0;
        case (state)
            DONE_IDLE: begin
                if (in_done && !wait_fall) state_n = DONE_PENDING;
            end
            DONE_PENDING: begin
                if (fifo_empty && !vga_plot && !wr_en) state_n = DONE_FIRE;
            end
            DONE_FIRE: begin
                done    = 1'b1;
                state_n = DONE_IDLE;
            end
            default: state_n = DONE_IDLE;
        endcase
    end

endmodule

// File: tb/tb_plot_fifo.sv
// Self-checking bench for plot_fifo: vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_plot_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_x;
    logic [6:0]  in_y;
    logic [2:0]  in_colour;
    logic        in_plot;
    logic        in_done;
    logic        stat_clr;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        vga_ready;
    logic        done;
    logic        empty;
    logic        overflow;
    logic [15:0] clip_cnt;

    always #5 clk = ~clk;

    plot_fifo #(
        .DEPTH    (DEPTH),
        .SCREEN_W (160),
        .SCREEN_H (120)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_colour  (in_colour),
        .in_plot    (in_plot),
        .in_done    (in_done),
        .stat_clr   (stat_clr),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .vga_ready  (vga_ready),
        .done       (done),
        .empty      (empty),
        .overflow   (overflow),
        .clip_cnt   (clip_cnt)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic        plot;
        logic [7:0]  x;
        logic [6:0]  y;
        logic [2:0]  c;
        logic        ready;
        logic        e_plot;
        logic [7:0]  e_x;
        logic [6:0]  e_y;
        logic [2:0]  e_c;
        logic [15:0] e_clip;
    } vec_t;

    vec_t vecs [8];

    // reference model state
    logic [17:0] mq [$];
    logic        m_plot;
    logic [17:0] m_pix;
    logic        m_ovf;
    int unsigned m_clip;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_plot   = 1'b0;
        in_done   = 1'b0;
        stat_clr  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_colour = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [17:0] e_pix;
        int          n;
        int          xfers;
        int          dones;
        int          last_xfer;
        int          done_c;
        int          early;
        int          seen;
        logic        xfer_pending;
        logic        on_screen;
        logic        was_full;

        vga_ready = 1'b1;
        do_reset();

        // reset state
        check("rst_vga_plot", vga_plot, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_done", done, 0);
        check("rst_empty", empty, 1);
        check("rst_overflow", overflow, 0);
        check("rst_clip_cnt", clip_cnt, 0);

        // single pixel then clipping, one row per clock
        vecs[0] = '{1'b1, 8'd80,  7'd60,  3'd2, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd0};
        vecs[1] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b1, 8'd80,  7'd60,  3'd2, 16'd0};
        vecs[2] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd0};
        vecs[3] = '{1'b1, 8'd160, 7'd10,  3'd1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd1};
        vecs[4] = '{1'b1, 8'd10,  7'd120, 3'd1, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd2};
        vecs[5] = '{1'b1, 8'd159, 7'd119, 3'd5, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd2};
        vecs[6] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b1, 8'd159, 7'd119, 3'd5, 16'd2};
        vecs[7] = '{1'b0, 8'd0,   7'd0,   3'd0, 1'b1, 1'b0, 8'd0,   7'd0,   3'd0, 16'd2};
        for (int i = 0; i < 8; i++) begin
            in_plot   = vecs[i].plot;
            in_x      = vecs[i].x;
            in_y      = vecs[i].y;
            in_colour = vecs[i].c;
            vga_ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_plot", i), vga_plot, vecs[i].e_plot);
            if (vecs[i].e_plot)
                check($sformatf("vec%0d_pix", i), {vga_x, vga_y, vga_colour},
                      {vecs[i].e_x, vecs[i].e_y, vecs[i].e_c});
            check($sformatf("vec%0d_clip", i), clip_cnt, vecs[i].e_clip);
        end
        idle_inputs();

        // backpressure and overflow
        do_reset();
        vga_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            in_plot   = 1'b1;
            in_x      = 8'(i + 3);
            in_y      = 7'(i * 2);
            in_colour = 3'(i);
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_plot", vga_plot, 1);
            check("bp_hold_pix", {vga_x, vga_y, vga_colour}, {8'd3, 7'd0, 3'd0});
            tick();
        end
        check("bp_overflow", overflow, 1);
        check("bp_clip", clip_cnt, 0);
        vga_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (vga_plot) begin
                e_pix = {8'(n + 3), 7'(n * 2), 3'(n)};
                check($sformatf("bp_order%0d", n), {vga_x, vga_y, vga_colour}, e_pix);
                n++;
            end
            tick();
        end
        check("bp_delivered", n, 17);
        check("bp_empty", empty, 1);
        check("bp_overflow_sticky", overflow, 1);
        // stat_clr coinciding with a clip event
        stat_clr = 1'b1;
        in_plot  = 1'b1;
        in_x     = 8'd200;
        tick();
        idle_inputs();
        check("clr_clip", clip_cnt, 0);
        check("clr_overflow", overflow, 0);

        // done ordering with toggling ready and in_done held high
        do_reset();
        xfers = 0; dones = 0; last_xfer = -10; done_c = -10; early = 0;
        for (int c = 0; c < 40; c++) begin
            in_plot   = (c < 5);
            in_x      = 8'(c * 10);
            in_y      = 7'(c);
            in_colour = 3'(c);
            in_done   = (c >= 5);
            vga_ready = c[0];
            xfer_pending = vga_plot & vga_ready;
            tick();
            if (xfer_pending) begin xfers++; last_xfer = c; end
            if (done) begin
                dones++;
                done_c = c;
                if (xfers < 5) early = 1;
            end
        end
        check("done_xfers", xfers, 5);
        check("done_once", dones, 1);
        check("done_not_early", early, 0);
        check("done_latency", done_c - last_xfer, 1);
        in_plot = 1'b0;
        in_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (done) dones++;
        end
        in_done = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done) dones++;
        end
        in_done = 1'b0;
        check("done_rearm", dones, 2);

        // reset mid-drain discards pixels and the pending done
        do_reset();
        vga_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            in_plot = 1'b1;
            in_x    = 8'(i);
            in_y    = 7'(i);
            tick();
        end
        in_plot = 1'b0;
        in_done = 1'b1;
        tick();
        in_done = 1'b0;
        check("mid_pre_overflow", overflow, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_plot", vga_plot, 0);
        check("mid_empty", empty, 1);
        check("mid_overflow", overflow, 0);
        vga_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (vga_plot || done) seen++;
        end
        check("mid_quiet", seen, 0);

        // clip counter saturation
        do_reset();
        in_plot = 1'b1;
        in_x    = 8'd200;
        in_y    = 7'd5;
        for (int c = 0; c < 65540; c++) tick();
        check("sat_clip", clip_cnt, 65535);
        stat_clr = 1'b1;
        tick();
        check("sat_clr_wins", clip_cnt, 0);
        idle_inputs();

        // randomized run against the queue model
        do_reset();
        mq.delete();
        m_plot = 1'b0; m_pix = '0; m_ovf = 1'b0; m_clip = 0;
        for (int c = 0; c < 800; c++) begin
            in_plot   = ($urandom_range(0, 9) < 7);
            in_x      = 8'($urandom_range(0, 199));
            in_y      = 7'($urandom_range(0, 127));
            in_colour = 3'($urandom_range(0, 7));
            vga_ready = (c < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            stat_clr  = ($urandom_range(0, 49) == 0);

            on_screen = in_plot && (in_x < 160) && (in_y < 120);
            was_full  = (mq.size() >= DEPTH);
            if (mq.size() > 0 && (!m_plot || vga_ready)) begin
                m_pix  = mq.pop_front();
                m_plot = 1'b1;
            end else if (m_plot && vga_ready) begin
                m_plot = 1'b0;
            end
            if (on_screen) begin
                if (!was_full) mq.push_back({in_x, in_y, in_colour});
                else m_ovf = 1'b1;
            end
            if (in_plot && !on_screen && m_clip < 65535) m_clip++;
            if (stat_clr) begin m_clip = 0; m_ovf = 1'b0; end

            tick();
            check("rnd_plot", vga_plot, m_plot);
            if (m_plot) check("rnd_pix", {vga_x, vga_y, vga_colour}, m_pix);
            check("rnd_overflow", overflow, m_ovf);
            check("rnd_clip", clip_cnt, m_clip);
            check("rnd_empty", empty, (mq.size() == 0) && !m_plot);
        end
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
